// File: rtl/mac_output_stage_if.sv
// Valid/ready stream carrying requantized results from the MAC output stage
// to the next layer.
interface mac_output_stage_if #(
   parameter int W = 14
) ();
   logic signed [W-1:0] data;
   logic                valid;
   logic                ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/mac_output_stage.sv
// Keeps the final sum of each VEC_LEN-long dot product from the MAC, clears the
// MAC, requantizes the sum and queues it in a small FIFO for the next layer.
module mac_output_stage #(
   parameter int IN_W       = 28,
   parameter int OUT_W      = 14,
   parameter int SHIFT      = 8,
   parameter int RELU       = 0,
   parameter int VEC_LEN    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic signed [IN_W-1:0]        in_data,
   input  logic                          in_valid,
   output logic                          mac_clear,
   output logic                          mac_hold,
   mac_output_stage_if.master            out_bus,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int EW    = IN_W + 1;
   localparam int RND   = (1 << SHIFT) >> 1;
   localparam logic [CNT_W-1:0]      LAST    = CNT_W'(VEC_LEN - 1);
   localparam logic [PTR_W:0]        FULL_N  = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic signed [EW-1:0]  SAT_MAX = EW'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [EW-1:0]  SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {ACCUM, CLEAR, FLUSH} state_t;

   state_t                  state, nextState;
   logic [CNT_W-1:0]        count;
   logic                    capture;
   logic signed [EW-1:0]    wide;
   logic signed [EW-1:0]    shifted;
   logic signed [OUT_W-1:0] quant;

   logic signed [OUT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wrPtr, rdPtr;
   logic [PTR_W:0]          used;
   logic                    full, empty, pop, push;

   // One extra bit of headroom keeps the rounding add from wrapping.
   always_comb begin
      wide    = {in_data[IN_W-1], in_data} + EW'(RND);
      shifted = wide >>> SHIFT;
      if (RELU != 0 && shifted[EW-1]) shifted = '0;
      if (shifted > SAT_MAX)      quant = SAT_MAX[OUT_W-1:0];
      else if (shifted < SAT_MIN) quant = SAT_MIN[OUT_W-1:0];
      else                        quant = shifted[OUT_W-1:0];
   end

   always_comb begin
      nextState = state;
      capture   = 1'b0;
      mac_clear = 1'b0;
      case (state)
         ACCUM: begin
            if (in_valid && count == LAST) begin
               capture   = 1'b1;
               nextState = CLEAR;
            end
         end
         CLEAR: begin
            mac_clear = 1'b1;
            nextState = FLUSH;
         end
         FLUSH:   nextState = ACCUM;
         default: nextState = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ACCUM;
         count <= '0;
      end else begin
         state <= nextState;
         if (state == ACCUM && in_valid)
            count <= capture ? '0 : count + CNT_W'(1);
      end
   end

   // A full FIFO still accepts a new result if the head leaves on the same edge.
   assign full  = (used == FULL_N);
   assign empty = (used == '0);
   assign pop   = !empty && out_bus.ready;
   assign push  = capture && (!full || pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wrPtr    <= '0;
         rdPtr    <= '0;
         used     <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            mem[wrPtr] <= quant;
            wrPtr      <= wrPtr + PTR_W'(1);
         end
         if (pop) rdPtr <= rdPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   used <= used + (PTR_W + 1)'(1);
            2'b01:   used <= used - (PTR_W + 1)'(1);
            default: used <= used;
         endcase
         if (capture && !push) overflow <= 1'b1;
      end
   end

   assign out_bus.valid = !empty;
   assign out_bus.data  = mem[rdPtr];
   assign fifo_count    = used;
   assign mac_hold      = (state != ACCUM) || full;

endmodule
